// File: rtl/common.sv
// Shared pipeline-register and bypass types used across the core.
// REG_MEM_WB   : memory-stage output register feeding writeback.
// FORWARD_SOURCE : bypass record published by a stage to the operand muxes.
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] instrAddr;
        logic [31:0] instr;
        logic        skip;
        logic [4:0]  wd;
        logic        isWriteBack;
        logic        isMemRead;
        logic        isJump;
        logic [63:0] memOut;
        logic [63:0] pcPlus4;
        logic [63:0] aluOut;
        logic        isCSRWrite;
        logic [11:0] CSR_addr;
        logic [63:0] CSR_write_value;
        logic        isCSRWrite2;
        logic [11:0] CSR_addr2;
        logic [63:0] CSR_write_value2;
        logic        isCSRWrite3;
        logic [11:0] CSR_addr3;
        logic [63:0] CSR_write_value3;
    } REG_MEM_WB;

    typedef struct packed {
        logic        valid;
        logic        isWb;
        logic [4:0]  wd;
        logic [63:0] wdData;
    } FORWARD_SOURCE;

endpackage

// File: rtl/csr_pkg.sv
// CSR-related constants and the writeback CSR sequencer state encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOT2 = 2'd1,
        SLOT3 = 2'd2,
        DONE  = 2'd3
    } wb_csr_state_t;

endpackage

// File: rtl/writeback_csrWriteSequencer.sv
// csrWriteSequencer: serialises up to three CSR writes of one instruction
// onto the single CSR-file write port, one slot per cycle in slot order.
// seqDone reports that the instruction may leave WB this cycle. Once the
// last slot has issued and the pipeline is not advancing, the FSM parks in
// DONE so no write is ever repeated.
module csrWriteSequencer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        ok_to_proceed_overall,
    input  logic        isCSRWrite,
    input  logic [11:0] csrAddr1,
    input  logic [63:0] csrData1,
    input  logic        isCSRWrite2,
    input  logic [11:0] csrAddr2,
    input  logic [63:0] csrData2,
    input  logic        isCSRWrite3,
    input  logic [11:0] csrAddr3,
    input  logic [63:0] csrData3,
    output logic        csrWen,
    output logic [11:0] csrAddr,
    output logic [63:0] csrWdata,
    output logic        seqDone
);

    wb_csr_state_t state_p0;
    wb_csr_state_t state_nxt;
    logic          active;
    logic          last_slot;

    assign active = valid & isCSRWrite;

    // State register; asynchronous reset abandons any partial sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // Slot mux, next-state and completion; pipeline advance returns to IDLE.
    always_comb begin
        state_nxt = state_p0;
        csrWen    = 1'b0;
        csrAddr   = 12'h000;
        csrWdata  = 64'h0;
        last_slot = 1'b0;
        case (state_p0)
            IDLE: begin
                if (active) begin
                    csrWen   = 1'b1;
                    csrAddr  = csrAddr1;
                    csrWdata = csrData1;
                    if (isCSRWrite2) begin
                        state_nxt = SLOT2;
                    end else begin
                        state_nxt = DONE;
                        last_slot = 1'b1;
                    end
                end
            end
            SLOT2: begin
                if (active) begin
                    csrWen   = 1'b1;
                    csrAddr  = csrAddr2;
                    csrWdata = csrData2;
                    if (isCSRWrite3) begin
                        state_nxt = SLOT3;
                    end else begin
                        state_nxt = DONE;
                        last_slot = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            SLOT3: begin
                if (active) begin
                    csrWen    = 1'b1;
                    csrAddr   = csrAddr3;
                    csrWdata  = csrData3;
                    last_slot = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                if (!active) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        seqDone = ~active | (state_p0 == DONE) | last_slot;
        if (ok_to_proceed_overall & seqDone) begin
            state_nxt = IDLE;
        end
    end

endmodule

// File: rtl/writeback.sv
// writeback: final pipeline stage. Selects the result, writes the GPR file,
// publishes the WB bypass, drives CSR writes through csrWriteSequencer,
// keeps minstret and emits a registered commit record per retirement.
// Optional feature macro: WB_COMMIT_TRACE_EN (commit-record registers);
// when undefined the commit* outputs are tied to zero.
module writeback
    import common::*;
    import csr_pkg::*;
#(
    parameter logic [11:0] CSR_MINSTRET_ADDR = CSR_MINSTRET
) (
    input  logic          clk,
    input  logic          rst,
    input  REG_MEM_WB     moduleIn,
    input  logic          ok_to_proceed_overall,
    output logic          ok_to_proceed,
    output FORWARD_SOURCE forwardSource,
    output logic          rfWen,
    output logic [4:0]    rfWa,
    output logic [63:0]   rfWd,
    output logic          csrWen,
    output logic [11:0]   csrAddr,
    output logic [63:0]   csrWdata,
    output logic [63:0]   minstret,
    output logic          commitValid,
    output logic [63:0]   commitPc,
    output logic [31:0]   commitInstr,
    output logic          commitSkip,
    output logic          commitWen,
    output logic [4:0]    commitWd,
    output logic [63:0]   commitWdata
);

    logic [63:0] wbData;
    logic        seqDone;
    logic        retire;
    logic [63:0] minstret_p1;

    // Result select and combinational GPR write / bypass.
    always_comb begin
        if (moduleIn.isMemRead) begin
            wbData = moduleIn.memOut;
        end else if (moduleIn.isJump) begin
            wbData = moduleIn.pcPlus4;
        end else begin
            wbData = moduleIn.aluOut;
        end
        rfWen                = moduleIn.valid & moduleIn.isWriteBack & (moduleIn.wd != 5'd0);
        rfWa                 = moduleIn.wd;
        rfWd                 = wbData;
        forwardSource.valid  = moduleIn.valid & (moduleIn.wd != 5'd0);
        forwardSource.isWb   = moduleIn.isWriteBack;
        forwardSource.wd     = moduleIn.wd;
        forwardSource.wdData = wbData;
    end

    csrWriteSequencer u_seq (
        .clk                   (clk),
        .rst                   (rst),
        .valid                 (moduleIn.valid),
        .ok_to_proceed_overall (ok_to_proceed_overall),
        .isCSRWrite            (moduleIn.isCSRWrite),
        .csrAddr1              (moduleIn.CSR_addr),
        .csrData1              (moduleIn.CSR_write_value),
        .isCSRWrite2           (moduleIn.isCSRWrite2),
        .csrAddr2              (moduleIn.CSR_addr2),
        .csrData2              (moduleIn.CSR_write_value2),
        .isCSRWrite3           (moduleIn.isCSRWrite3),
        .csrAddr3              (moduleIn.CSR_addr3),
        .csrData3              (moduleIn.CSR_write_value3),
        .csrWen                (csrWen),
        .csrAddr               (csrAddr),
        .csrWdata              (csrWdata),
        .seqDone               (seqDone)
    );

    assign ok_to_proceed = seqDone;
    assign retire        = moduleIn.valid & seqDone & ok_to_proceed_overall;
    assign minstret      = minstret_p1;

    // Retired-instruction counter; a CSR write to minstret wins over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            minstret_p1 <= 64'h0;
        end else if (csrWen && (csrAddr == CSR_MINSTRET_ADDR)) begin
            minstret_p1 <= csrWdata;
        end else if (retire) begin
            minstret_p1 <= minstret_p1 + 64'd1;
        end
    end

`ifdef WB_COMMIT_TRACE_EN
    logic        commit_vld_p1;
    logic [63:0] commit_pc_p1;
    logic [31:0] commit_instr_p1;
    logic        commit_skip_p1;
    logic        commit_wen_p1;
    logic [4:0]  commit_wd_p1;
    logic [63:0] commit_wdata_p1;

    // Commit record captured on each retirement, valid for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_vld_p1   <= 1'b0;
            commit_pc_p1    <= 64'h0;
            commit_instr_p1 <= 32'h0;
            commit_skip_p1  <= 1'b0;
            commit_wen_p1   <= 1'b0;
            commit_wd_p1    <= 5'd0;
            commit_wdata_p1 <= 64'h0;
        end else begin
            commit_vld_p1 <= retire;
            if (retire) begin
                commit_pc_p1    <= moduleIn.instrAddr;
                commit_instr_p1 <= moduleIn.instr;
                commit_skip_p1  <= moduleIn.skip;
                commit_wen_p1   <= rfWen;
                commit_wd_p1    <= moduleIn.wd;
                commit_wdata_p1 <= wbData;
            end
        end
    end

    assign commitValid = commit_vld_p1;
    assign commitPc    = commit_pc_p1;
    assign commitInstr = commit_instr_p1;
    assign commitSkip  = commit_skip_p1;
    assign commitWen   = commit_wen_p1;
    assign commitWd    = commit_wd_p1;
    assign commitWdata = commit_wdata_p1;
`else
    logic unused_trace;
    assign unused_trace = ^{moduleIn.instrAddr, moduleIn.instr, moduleIn.skip};

    assign commitValid = 1'b0;
    assign commitPc    = 64'h0;
    assign commitInstr = 32'h0;
    assign commitSkip  = 1'b0;
    assign commitWen   = 1'b0;
    assign commitWd    = 5'd0;
    assign commitWdata = 64'h0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: GPR write, bypass, CSR slot sequencing,
// stall parking, minstret load/wrap, commit record and mid-sequence reset.
module tb_writeback;
    import common::*;
    import csr_pkg::*;

`ifdef WB_COMMIT_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic          clk;
    logic          rst;
    REG_MEM_WB     mi;
    logic          overall;
    logic          ok;
    FORWARD_SOURCE fwd;
    logic          rfWen;
    logic [4:0]    rfWa;
    logic [63:0]   rfWd;
    logic          csrWen;
    logic [11:0]   csrAddr;
    logic [63:0]   csrWdata;
    logic [63:0]   minstret;
    logic          commitValid;
    logic [63:0]   commitPc;
    logic [31:0]   commitInstr;
    logic          commitSkip;
    logic          commitWen;
    logic [4:0]    commitWd;
    logic [63:0]   commitWdata;

    int total  = 0;
    int passed = 0;
    logic [63:0] exp_ms;

    writeback dut (
        .clk                   (clk),
        .rst                   (rst),
        .moduleIn              (mi),
        .ok_to_proceed_overall (overall),
        .ok_to_proceed         (ok),
        .forwardSource         (fwd),
        .rfWen                 (rfWen),
        .rfWa                  (rfWa),
        .rfWd                  (rfWd),
        .csrWen                (csrWen),
        .csrAddr               (csrAddr),
        .csrWdata              (csrWdata),
        .minstret              (minstret),
        .commitValid           (commitValid),
        .commitPc              (commitPc),
        .commitInstr           (commitInstr),
        .commitSkip            (commitSkip),
        .commitWen             (commitWen),
        .commitWd              (commitWd),
        .commitWdata           (commitWdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic REG_MEM_WB mk_add(input logic [4:0] wd, input logic [63:0] alu);
        REG_MEM_WB r;
        r = '0;
        r.valid = 1'b1; r.instrAddr = 64'h8000_0000; r.instr = 32'h0000_0033;
        r.isWriteBack = 1'b1; r.wd = wd; r.aluOut = alu;
        return r;
    endfunction

    function automatic REG_MEM_WB mk_ecall();
        REG_MEM_WB r;
        r = '0;
        r.valid = 1'b1; r.instrAddr = 64'h8000_0100; r.instr = 32'h0000_0073;
        r.isCSRWrite  = 1'b1; r.CSR_addr  = 12'h300; r.CSR_write_value  = 64'h1800;
        r.isCSRWrite2 = 1'b1; r.CSR_addr2 = 12'h341; r.CSR_write_value2 = 64'h8000_0100;
        r.isCSRWrite3 = 1'b1; r.CSR_addr3 = 12'h342; r.CSR_write_value3 = 64'd8;
        return r;
    endfunction

    function automatic REG_MEM_WB mk_csrw(input logic [11:0] a, input logic [63:0] v);
        REG_MEM_WB r;
        r = '0;
        r.valid = 1'b1; r.instrAddr = 64'h8000_0200; r.instr = 32'h3020_0073;
        r.isCSRWrite = 1'b1; r.CSR_addr = a; r.CSR_write_value = v;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; overall = 1'b1; mi = '0;
        #12;
        total++; if (minstret !== 64'h0) $display("FAIL rst_minstret: got %h expected 0", minstret); else passed++;
        total++; if (commitValid !== 1'b0) $display("FAIL rst_commitValid: got %b expected 0", commitValid); else passed++;
        total++; if (rfWen !== 1'b0) $display("FAIL rst_rfWen: got %b expected 0", rfWen); else passed++;
        total++; if (csrWen !== 1'b0) $display("FAIL rst_csrWen: got %b expected 0", csrWen); else passed++;
        total++; if (ok !== 1'b1) $display("FAIL rst_ok: got %b expected 1", ok); else passed++;
        rst = 1'b0;
        exp_ms = 64'h0;
        cyc();
    endtask

    task automatic test_add();
        mi = mk_add(5'd5, 64'h1234);
        #1;
        total++; if (rfWen !== 1'b1) $display("FAIL add_rfWen: got %b expected 1", rfWen); else passed++;
        total++; if (rfWa !== 5'd5) $display("FAIL add_rfWa: got %0d expected 5", rfWa); else passed++;
        total++; if (rfWd !== 64'h1234) $display("FAIL add_rfWd: got %h expected 1234", rfWd); else passed++;
        total++; if (ok !== 1'b1) $display("FAIL add_ok: got %b expected 1", ok); else passed++;
        total++; if (fwd.valid !== 1'b1 || fwd.wdData !== 64'h1234) $display("FAIL add_fwd: got %b/%h expected 1/1234", fwd.valid, fwd.wdData); else passed++;
        cyc();
        exp_ms = exp_ms + 1;
        mi = '0;
        total++; if (commitValid !== TRACE) $display("FAIL add_commitValid: got %b expected %b", commitValid, TRACE); else passed++;
        total++; if (commitWdata !== (TRACE ? 64'h1234 : 64'h0)) $display("FAIL add_commitWdata: got %h expected %h", commitWdata, TRACE ? 64'h1234 : 64'h0); else passed++;
        total++; if (commitWd !== (TRACE ? 5'd5 : 5'd0)) $display("FAIL add_commitWd: got %0d", commitWd); else passed++;
        total++; if (minstret !== exp_ms) $display("FAIL add_minstret: got %h expected %h", minstret, exp_ms); else passed++;
        cyc();
        total++; if (commitValid !== 1'b0) $display("FAIL add_commit_drop: got %b expected 0", commitValid); else passed++;
        total++; if (minstret !== exp_ms) $display("FAIL add_idle_minstret: got %h expected %h", minstret, exp_ms); else passed++;
    endtask

    task automatic test_ld_wd0();
        mi = '0;
        mi.valid = 1'b1; mi.instrAddr = 64'h8000_0004; mi.instr = 32'h0000_3003;
        mi.isWriteBack = 1'b1; mi.isMemRead = 1'b1; mi.memOut = 64'hDEAD; mi.aluOut = 64'h55;
        #1;
        total++; if (rfWen !== 1'b0) $display("FAIL ld_rfWen: got %b expected 0", rfWen); else passed++;
        total++; if (fwd.valid !== 1'b0) $display("FAIL ld_fwd_valid: got %b expected 0", fwd.valid); else passed++;
        total++; if (rfWd !== 64'hDEAD) $display("FAIL ld_select: got %h expected dead", rfWd); else passed++;
        cyc();
        exp_ms = exp_ms + 1;
        mi = '0;
        total++; if (commitValid !== TRACE) $display("FAIL ld_commitValid: got %b expected %b", commitValid, TRACE); else passed++;
        total++; if (commitWen !== 1'b0) $display("FAIL ld_commitWen: got %b expected 0", commitWen); else passed++;
        total++; if (commitPc !== (TRACE ? 64'h8000_0004 : 64'h0)) $display("FAIL ld_commitPc: got %h", commitPc); else passed++;
        total++; if (minstret !== exp_ms) $display("FAIL ld_minstret: got %h expected %h", minstret, exp_ms); else passed++;
    endtask

    task automatic test_jump();
        mi = mk_add(5'd1, 64'h77);
        mi.isJump = 1'b1; mi.pcPlus4 = 64'h8000_0010;
        #1;
        total++; if (rfWd !== 64'h8000_0010) $display("FAIL jal_select: got %h expected 80000010", rfWd); else passed++;
        cyc();
        exp_ms = exp_ms + 1;
        mi = '0;
    endtask

    task automatic test_ecall();
        overall = 1'b1;
        mi = mk_ecall();
        #1;
        total++; if (csrWen !== 1'b1 || csrAddr !== 12'h300 || csrWdata !== 64'h1800) $display("FAIL ecall_c0: got %b/%h/%h expected 1/300/1800", csrWen, csrAddr, csrWdata); else passed++;
        total++; if (ok !== 1'b0) $display("FAIL ecall_ok0: got %b expected 0", ok); else passed++;
        cyc();
        total++; if (csrWen !== 1'b1 || csrAddr !== 12'h341) $display("FAIL ecall_c1: got %b/%h expected 1/341", csrWen, csrAddr); else passed++;
        total++; if (ok !== 1'b0) $display("FAIL ecall_ok1: got %b expected 0", ok); else passed++;
        total++; if (minstret !== exp_ms) $display("FAIL ecall_no_inc: got %h expected %h", minstret, exp_ms); else passed++;
        cyc();
        total++; if (csrWen !== 1'b1 || csrAddr !== 12'h342 || csrWdata !== 64'd8) $display("FAIL ecall_c2: got %b/%h/%h expected 1/342/8", csrWen, csrAddr, csrWdata); else passed++;
        total++; if (ok !== 1'b1) $display("FAIL ecall_ok2: got %b expected 1", ok); else passed++;
        cyc();
        exp_ms = exp_ms + 1;
        mi = '0;
        #1;
        total++; if (minstret !== exp_ms) $display("FAIL ecall_minstret: got %h expected %h", minstret, exp_ms); else passed++;
        total++; if (csrWen !== 1'b0) $display("FAIL ecall_after: got %b expected 0", csrWen); else passed++;
    endtask

    task automatic test_mret_stall();
        int pulses;
        pulses = 0;
        overall = 1'b0;
        mi = mk_csrw(12'h300, 64'h88);
        #1;
        total++; if (csrWen !== 1'b1 || csrAddr !== 12'h300) $display("FAIL mret_c0: got %b/%h expected 1/300", csrWen, csrAddr); else passed++;
        for (int i = 0; i < 3; i++) begin
            if (csrWen === 1'b1) pulses++;
            total++; if (ok !== 1'b1) $display("FAIL mret_ok_c%0d: got %b expected 1", i, ok); else passed++;
            cyc();
        end
        total++; if (pulses !== 1) $display("FAIL mret_pulses: got %0d expected 1", pulses); else passed++;
        total++; if (minstret !== exp_ms) $display("FAIL mret_stall_minstret: got %h expected %h", minstret, exp_ms); else passed++;
        overall = 1'b1;
        #1;
        total++; if (csrWen !== 1'b0 || ok !== 1'b1) $display("FAIL mret_release: got wen %b ok %b expected 0/1", csrWen, ok); else passed++;
        cyc();
        exp_ms = exp_ms + 1;
        mi = '0;
        total++; if (minstret !== exp_ms) $display("FAIL mret_minstret: got %h expected %h", minstret, exp_ms); else passed++;
    endtask

    task automatic test_minstret_write();
        overall = 1'b1;
        mi = mk_csrw(CSR_MINSTRET, 64'd100);
        #1;
        total++; if (csrWen !== 1'b1 || ok !== 1'b1) $display("FAIL csrw_issue: got wen %b ok %b expected 1/1", csrWen, ok); else passed++;
        cyc();
        total++; if (minstret !== 64'd100) $display("FAIL csrw_minstret: got %0d expected 100", minstret); else passed++;
        mi = mk_csrw(CSR_MINSTRET, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        total++; if (minstret !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL csrw_max: got %h expected ffffffffffffffff", minstret); else passed++;
        mi = mk_add(5'd2, 64'h9);
        cyc();
        mi = '0;
        total++; if (minstret !== 64'h0) $display("FAIL minstret_wrap: got %h expected 0", minstret); else passed++;
        exp_ms = 64'h0;
    endtask

    task automatic test_back_to_back();
        mi = mk_add(5'd3, 64'hA1);
        cyc();
        mi = mk_add(5'd4, 64'hB2);
        total++; if (commitWdata !== (TRACE ? 64'hA1 : 64'h0)) $display("FAIL b2b_first: got %h", commitWdata); else passed++;
        cyc();
        mi = '0;
        exp_ms = exp_ms + 2;
        total++; if (commitValid !== TRACE || commitWdata !== (TRACE ? 64'hB2 : 64'h0)) $display("FAIL b2b_second: got %b/%h", commitValid, commitWdata); else passed++;
        total++; if (minstret !== exp_ms) $display("FAIL b2b_minstret: got %h expected %h", minstret, exp_ms); else passed++;
    endtask

    task automatic test_rst_mid();
        mi = mk_add(5'd7, 64'h4242);
        cyc();
        mi = mk_ecall();
        cyc();
        total++; if (csrAddr !== 12'h341) $display("FAIL rstmid_slot2: got %h expected 341", csrAddr); else passed++;
        #1;
        rst = 1'b1;
        mi = '0;
        #1;
        total++; if (minstret !== 64'h0) $display("FAIL rstmid_minstret: got %h expected 0", minstret); else passed++;
        total++; if (commitValid !== 1'b0 || commitPc !== 64'h0 || commitWdata !== 64'h0 || commitWd !== 5'd0) $display("FAIL rstmid_commit: got %b/%h/%h expected zeros", commitValid, commitPc, commitWdata); else passed++;
        total++; if (csrWen !== 1'b0 || ok !== 1'b1) $display("FAIL rstmid_outs: got wen %b ok %b expected 0/1", csrWen, ok); else passed++;
        cyc();
        rst = 1'b0;
        #1;
        total++; if (csrWen !== 1'b0) $display("FAIL rstmid_no_slot3: got %b expected 0", csrWen); else passed++;
        mi = mk_ecall();
        #1;
        total++; if (csrWen !== 1'b1 || csrAddr !== 12'h300) $display("FAIL rstmid_restart: got %b/%h expected 1/300", csrWen, csrAddr); else passed++;
        cyc();
        cyc();
        total++; if (csrAddr !== 12'h342 || ok !== 1'b1) $display("FAIL rstmid_c2: got %h ok %b expected 342/1", csrAddr, ok); else passed++;
        cyc();
        mi = '0;
        total++; if (minstret !== 64'd1) $display("FAIL rstmid_count: got %h expected 1", minstret); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld_wd0();
        test_jump();
        test_ecall();
        test_mret_stall();
        test_minstret_write();
        test_back_to_back();
        test_rst_mid();
        cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
